id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised, pipelined instruction-decode stage for the RV32-style core. It contains:
- the register file, with hardwired x0 and write-through;
- the write-back source mux;
- the immediate sign-extender;
- operand forwarding from EX;
- load-use hazard detection;
- a registered ID/EX output with valid/ready handshake and flush.

It sits between the IF/ID register and the EX stage. It receives write-back traffic from WB.

Parameters:
XLEN, 32, datapath width (immediates sign-extended to XLEN)
NREG, 32, number of architectural registers; AW = clog2(NREG) index bits
FWD_EN, 1, 1 = forward EX ALU result to operands; 0 = stall on any EX RAW

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_inst  in  32  instruction word; rR1=inst[19:15], rR2=inst[24:20], wR=inst[11:7] (low AW bits)
in_pc4  in  XLEN  PC+4 of instruction
in_sext_op  in  3  0=I,1=S,2=B,3=U,4=J, others -> 0
in_rf_we  in  1  instruction writes RF
in_rf_wsel  in  2  0=ALU,1=PC4,2=EXT,3=RDO
in_is_load  in  1  instruction is a load
flush  in  1  kill ID/EX contents and current acceptance
ex_valid, ex_rf_we, ex_is_load  in  1 each  EX-stage status
ex_wR  in  AW  EX destination
ex_alu_c  in  XLEN  EX ALU result
wb_we  in  1  WB write enable
wb_wR  in  AW  WB destination
wb_wsel  in  2  WB source select, encoding as in_rf_wsel
wb_alu_c, wb_pc4, wb_ext, wb_dram_rdo  in  XLEN each  WB candidates
rf_wD  out  XLEN  muxed WB data (debug, combinational)
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
out_rD1, out_rD2, out_ext, out_pc4  out  XLEN each  registered operands, immediate, PC+4
out_wR, out_rR1, out_rR2  out  AW each  registered indices
out_rf_we, out_is_load  out  1 each
out_rf_wsel  out  2

Behaviour:
- Reset (rst_n=0, async): all RF entries=0; out_valid=0; every registered output=0.
- WB mux: rf_wD = ALU/PC4/EXT/RDO per wb_wsel.
- RF write: on the clk edge when wb_we && wb_wR!=0. Writes to x0 are ignored; x0 always reads 0.
- Operand select, per port, priority order:
  - rR==0 -> 0.
  - FWD_EN && ex_valid && ex_rf_we && !ex_is_load && ex_wR==rR -> ex_alu_c.
  - wb_we && wb_wR==rR -> rf_wD (write-through, same cycle).
  - otherwise the RF array.
- hazard = in_valid && ex_valid && ex_rf_we && ex_wR!=0 && (ex_wR==rR1 || ex_wR==rR2) && (ex_is_load || !FWD_EN).
  - Both indices are compared unconditionally (conservative).
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - load = in_valid && in_ready: ID/EX captures all fields, out_valid=1.
  - Else if out_ready (or out_valid=0): out_valid=0 (bubble inserted). Data fields hold.
  - Else (out_valid && !out_ready): all outputs hold.
- flush: next edge out_valid=0, no capture. Flush overrides load and stall.
- Latency: 1 cycle from accepted input to out_valid.
- Sign extension (in 32-bit terms, extended to XLEN):
  - I = inst[31:20].
  - S = {inst[31:25],inst[11:7]}.
  - B = {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U = {inst[31:12],12'b0}.
  - J = {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- Boundaries:
  - Simultaneous WB write and ID read of the same register: new value is read.
  - EX and WB target the same register: EX wins.
  - Reset asserted mid-stall clears out_valid; the RF is cleared.

Test Plan:
1. Reset, then WB writes x5=0x1234 (wb_wsel=0) while ID reads rR1=5 the same cycle -> next cycle out_rD1=0x1234, rf_wD=0x1234.
2. WB writes x0=0xFFFF, then ID reads rR1=0 -> out_rD1=0.
3. EX non-load writing x7 with ex_alu_c=0xAA, ID reads rR2=7, FWD_EN=1 -> out_rD2=0xAA, no stall. Same stimulus with FWD_EN=0 -> in_ready=0 and a bubble while EX holds x7.
4. ex_is_load writing x3, ID reads rR1=3 -> in_ready=0 one cycle, out_valid=0. When EX clears, the instruction is accepted and the operand comes from WB write-through.
5. out_ready=0 with out_valid=1 for 3 cycles -> outputs stable, in_ready=0. Then out_ready=1 -> next instruction captured.
6. in_inst=0xFFF00093 with sext_op=0 -> out_ext=0xFFFFFFFF. Assert flush the same cycle as a valid input -> out_valid=0 next cycle.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file with write-through, WB source mux,
// immediate sign-extension, EX->ID forwarding, load-use hazard detection and
// a registered ID/EX output with valid/ready handshake and flush.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int FWD_EN = 1,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  // upstream (IF/ID)
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [2:0]      in_sext_op,
  input  logic            in_rf_we,
  input  logic [1:0]      in_rf_wsel,
  input  logic            in_is_load,
  input  logic            flush,
  // EX status
  input  logic            ex_valid,
  input  logic            ex_rf_we,
  input  logic            ex_is_load,
  input  logic [AW-1:0]   ex_wR,
  input  logic [XLEN-1:0] ex_alu_c,
  // WB traffic
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_wR,
  input  logic [1:0]      wb_wsel,
  input  logic [XLEN-1:0] wb_alu_c,
  input  logic [XLEN-1:0] wb_pc4,
  input  logic [XLEN-1:0] wb_ext,
  input  logic [XLEN-1:0] wb_dram_rdo,
  output logic [XLEN-1:0] rf_wD,
  // downstream (ID/EX)
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rD1,
  output logic [XLEN-1:0] out_rD2,
  output logic [XLEN-1:0] out_ext,
  output logic [XLEN-1:0] out_pc4,
  output logic [AW-1:0]   out_wR,
  output logic [AW-1:0]   out_rR1,
  output logic [AW-1:0]   out_rR2,
  output logic            out_rf_we,
  output logic            out_is_load,
  output logic [1:0]      out_rf_wsel
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] pc4;
    logic [AW-1:0]   wr;
    logic [AW-1:0]   rr1;
    logic [AW-1:0]   rr2;
    logic            rf_we;
    logic            is_load;
    logic [1:0]      wsel;
  } idex_t;

  logic [XLEN-1:0] rf_q [NREG];
  idex_t           idex_q, idex_d;
  logic            valid_q;

  logic [AW-1:0]   rr1, rr2, wr;
  logic [31:0]     imm32;
  logic            ex_fwd_ok, ex_stall_cls, hazard, load;
  logic            unused_inst;

  assign rr1 = in_inst[15 +: AW];
  assign rr2 = in_inst[20 +: AW];
  assign wr  = in_inst[7  +: AW];
  // Opcode bits select nothing here; decode happens upstream.
  assign unused_inst = ^in_inst[6:0];

  // Write-back source mux.
  always_comb begin
    unique case (wb_wsel)
      2'd0:    rf_wD = wb_alu_c;
      2'd1:    rf_wD = wb_pc4;
      2'd2:    rf_wD = wb_ext;
      default: rf_wD = wb_dram_rdo;
    endcase
  end

  // Register file write port; x0 is never written.
  // NOTE: the RF array is reset entry by entry because cleared registers are
  // architecturally visible after reset; this costs a flop array, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_wR != '0) begin
      rf_q[wb_wR] <= rf_wD;
    end
  end

  // Immediate generation in 32-bit terms, sign-extended to XLEN afterwards.
  always_comb begin
    imm32 = '0;
    unique case (in_sext_op)
      3'd0: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      3'd1: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      3'd2: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
      3'd3: imm32 = {in_inst[31:12], 12'b0};
      3'd4: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign ex_fwd_ok    = (FWD_EN != 0) && ex_valid && ex_rf_we && !ex_is_load;
  // EX results that cannot be forwarded: loads always, everything without FWD_EN.
  assign ex_stall_cls = ex_is_load || (FWD_EN == 0);

  // Operand select: x0, then EX forward, then WB write-through, then array.
  // NOTE: every comb output gets a default before the if-chain so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    idex_d         = '0;
    idex_d.ext     = XLEN'($signed(imm32));
    idex_d.pc4     = in_pc4;
    idex_d.wr      = wr;
    idex_d.rr1     = rr1;
    idex_d.rr2     = rr2;
    idex_d.rf_we   = in_rf_we;
    idex_d.is_load = in_is_load;
    idex_d.wsel    = in_rf_wsel;

    if (rr1 == '0)                          idex_d.rd1 = '0;
    else if (ex_fwd_ok && ex_wR == rr1)     idex_d.rd1 = ex_alu_c;
    else if (wb_we && wb_wR == rr1)         idex_d.rd1 = rf_wD;
    else                                    idex_d.rd1 = rf_q[rr1];

    if (rr2 == '0)                          idex_d.rd2 = '0;
    else if (ex_fwd_ok && ex_wR == rr2)     idex_d.rd2 = ex_alu_c;
    else if (wb_we && wb_wR == rr2)         idex_d.rd2 = rf_wD;
    else                                    idex_d.rd2 = rf_q[rr2];
  end

  // Hazard and handshake; both source indices are compared even if unused.
  assign hazard = in_valid && ex_valid && ex_rf_we && (ex_wR != '0) &&
                  (ex_wR == rr1 || ex_wR == rr2) && ex_stall_cls;
  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign load     = in_valid && in_ready;

  // ID/EX register: flush kills, load captures, drained slot becomes a bubble.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      idex_q  <= idex_d;
    end else if (out_ready || !valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_rD1     = idex_q.rd1;
  assign out_rD2     = idex_q.rd2;
  assign out_ext     = idex_q.ext;
  assign out_pc4     = idex_q.pc4;
  assign out_wR      = idex_q.wr;
  assign out_rR1     = idex_q.rr1;
  assign out_rR2     = idex_q.rr2;
  assign out_rf_we   = idex_q.rf_we;
  assign out_is_load = idex_q.is_load;
  assign out_rf_wsel = idex_q.wsel;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one forwarding instance and one
// stall-only instance share stimulus; expected values are hand-computed.
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk, rst_n;
  logic            in_valid, flush, in_rf_we, in_is_load, out_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc4;
  logic [2:0]      in_sext_op;
  logic [1:0]      in_rf_wsel, wb_wsel;
  logic            ex_valid, ex_rf_we, ex_is_load, wb_we;
  logic [AW-1:0]   ex_wR, wb_wR;
  logic [XLEN-1:0] ex_alu_c, wb_alu_c, wb_pc4, wb_ext, wb_dram_rdo;

  // forwarding instance outputs
  logic            f_in_ready, f_out_valid, f_out_rf_we, f_out_is_load;
  logic [XLEN-1:0] f_rf_wD, f_out_rD1, f_out_rD2, f_out_ext, f_out_pc4;
  logic [AW-1:0]   f_out_wR, f_out_rR1, f_out_rR2;
  logic [1:0]      f_out_rf_wsel;
  // stall-only instance outputs
  logic            n_in_ready, n_out_valid, n_out_rf_we, n_out_is_load;
  logic [XLEN-1:0] n_rf_wD, n_out_rD1, n_out_rD2, n_out_ext, n_out_pc4;
  logic [AW-1:0]   n_out_wR, n_out_rR1, n_out_rR2;
  logic [1:0]      n_out_rf_wsel;

  int checks = 0;
  int errors = 0;

  id_stage_pipe #(.XLEN(XLEN), .NREG(32), .FWD_EN(1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(f_in_ready), .in_inst(in_inst),
    .in_pc4(in_pc4), .in_sext_op(in_sext_op), .in_rf_we(in_rf_we),
    .in_rf_wsel(in_rf_wsel), .in_is_load(in_is_load), .flush(flush),
    .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .ex_wR(ex_wR), .ex_alu_c(ex_alu_c),
    .wb_we(wb_we), .wb_wR(wb_wR), .wb_wsel(wb_wsel), .wb_alu_c(wb_alu_c),
    .wb_pc4(wb_pc4), .wb_ext(wb_ext), .wb_dram_rdo(wb_dram_rdo),
    .rf_wD(f_rf_wD),
    .out_valid(f_out_valid), .out_ready(out_ready),
    .out_rD1(f_out_rD1), .out_rD2(f_out_rD2), .out_ext(f_out_ext),
    .out_pc4(f_out_pc4), .out_wR(f_out_wR), .out_rR1(f_out_rR1),
    .out_rR2(f_out_rR2), .out_rf_we(f_out_rf_we),
    .out_is_load(f_out_is_load), .out_rf_wsel(f_out_rf_wsel)
  );

  id_stage_pipe #(.XLEN(XLEN), .NREG(32), .FWD_EN(0)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_inst(in_inst),
    .in_pc4(in_pc4), .in_sext_op(in_sext_op), .in_rf_we(in_rf_we),
    .in_rf_wsel(in_rf_wsel), .in_is_load(in_is_load), .flush(flush),
    .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .ex_wR(ex_wR), .ex_alu_c(ex_alu_c),
    .wb_we(wb_we), .wb_wR(wb_wR), .wb_wsel(wb_wsel), .wb_alu_c(wb_alu_c),
    .wb_pc4(wb_pc4), .wb_ext(wb_ext), .wb_dram_rdo(wb_dram_rdo),
    .rf_wD(n_rf_wD),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .out_rD1(n_out_rD1), .out_rD2(n_out_rD2), .out_ext(n_out_ext),
    .out_pc4(n_out_pc4), .out_wR(n_out_wR), .out_rR1(n_out_rR1),
    .out_rR2(n_out_rR2), .out_rf_we(n_out_rf_we),
    .out_is_load(n_out_is_load), .out_rf_wsel(n_out_rf_wsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("%s mismatch", tag);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; in_inst = '0; in_pc4 = '0; in_sext_op = '0;
    in_rf_we = 0; in_rf_wsel = '0; in_is_load = 0; out_ready = 1;
    ex_valid = 0; ex_rf_we = 0; ex_is_load = 0; ex_wR = '0; ex_alu_c = '0;
    wb_we = 0; wb_wR = '0; wb_wsel = '0; wb_alu_c = '0; wb_pc4 = '0;
    wb_ext = '0; wb_dram_rdo = '0;
  endtask

  // R-type word with the given register fields.
  task automatic set_inst(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    in_inst = {7'b0, rs2, rs1, 3'b0, rd, 7'b0110011};
    in_sext_op = 3'd0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    check("reset_valid", {31'b0, f_out_valid}, 32'd0);
    check("reset_rD1", f_out_rD1, 32'd0);
    check("reset_ext", f_out_ext, 32'd0);
    check("reset_wR", {27'b0, f_out_wR}, 32'd0);
    #11 rst_n = 1;
    tick();

    // 1: WB writes x5 while ID reads x5 in the same cycle
    wb_we = 1; wb_wR = 5; wb_wsel = 0; wb_alu_c = 32'h1234;
    in_valid = 1; set_inst(5, 0, 1); in_rf_we = 1; in_pc4 = 32'h104;
    #1;
    check("t1_rf_wD", f_rf_wD, 32'h1234);
    check("t1_in_ready", {31'b0, f_in_ready}, 32'd1);
    tick();
    check("t1_valid", {31'b0, f_out_valid}, 32'd1);
    check("t1_rD1", f_out_rD1, 32'h1234);
    check("t1_rD2", f_out_rD2, 32'd0);
    check("t1_rR1", {27'b0, f_out_rR1}, 32'd5);
    check("t1_wR", {27'b0, f_out_wR}, 32'd1);
    check("t1_pc4", f_out_pc4, 32'h104);
    check("t1_rf_we", {31'b0, f_out_rf_we}, 32'd1);
    check("t1_ext", f_out_ext, 32'd0);
    // x5 now read from the array on port 2
    wb_we = 0; in_rf_we = 0; set_inst(0, 5, 2);
    tick();
    check("t1_array_rD2", f_out_rD2, 32'h1234);

    // WB mux sources
    in_valid = 0; wb_pc4 = 32'h11; wb_ext = 32'h22; wb_dram_rdo = 32'h33;
    wb_wsel = 1; #1 check("wbmux_pc4", f_rf_wD, 32'h11);
    wb_wsel = 2; #1 check("wbmux_ext", f_rf_wD, 32'h22);
    wb_wsel = 3; #1 check("wbmux_rdo", f_rf_wD, 32'h33);
    tick();

    // 2: write to x0 ignored, x0 always reads 0
    wb_we = 1; wb_wR = 0; wb_wsel = 0; wb_alu_c = 32'hFFFF;
    in_valid = 1; set_inst(0, 0, 3);
    tick();
    check("t2_x0_same_cycle", f_out_rD1, 32'd0);
    wb_we = 0;
    tick();
    check("t2_x0_after", f_out_rD1, 32'd0);

    // 3: EX non-load to x7 with a simultaneous WB to x7 -> EX wins
    ex_valid = 1; ex_rf_we = 1; ex_is_load = 0; ex_wR = 7; ex_alu_c = 32'hAA;
    wb_we = 1; wb_wR = 7; wb_wsel = 0; wb_alu_c = 32'h55;
    set_inst(0, 7, 4);
    #1;
    check("t3_fwd_in_ready", {31'b0, f_in_ready}, 32'd1);
    check("t3_nofwd_in_ready", {31'b0, n_in_ready}, 32'd0);
    tick();
    check("t3_fwd_valid", {31'b0, f_out_valid}, 32'd1);
    check("t3_fwd_rD2", f_out_rD2, 32'hAA);
    check("t3_nofwd_bubble", {31'b0, n_out_valid}, 32'd0);
    ex_valid = 0; wb_we = 0;
    #1 check("t3_nofwd_ready_again", {31'b0, n_in_ready}, 32'd1);
    tick();
    check("t3_nofwd_valid", {31'b0, n_out_valid}, 32'd1);
    check("t3_nofwd_rD2", n_out_rD2, 32'h55);

    // 4: load-use on x3 stalls, then operand arrives by write-through
    ex_valid = 1; ex_rf_we = 1; ex_is_load = 1; ex_wR = 3;
    set_inst(3, 0, 5);
    #1 check("t4_in_ready_stall", {31'b0, f_in_ready}, 32'd0);
    tick();
    check("t4_bubble", {31'b0, f_out_valid}, 32'd0);
    ex_valid = 0; ex_is_load = 0;
    wb_we = 1; wb_wR = 3; wb_wsel = 3; wb_dram_rdo = 32'hDEAD;
    #1 check("t4_in_ready_resume", {31'b0, f_in_ready}, 32'd1);
    tick();
    check("t4_valid", {31'b0, f_out_valid}, 32'd1);
    check("t4_rD1", f_out_rD1, 32'hDEAD);
    wb_we = 0;

    // 5: back-pressure holds the ID/EX register for three cycles
    set_inst(5, 0, 9);
    tick();
    check("t5_loaded_wR", {27'b0, f_out_wR}, 32'd9);
    out_ready = 0; set_inst(3, 0, 10);
    for (int i = 0; i < 3; i++) begin
      #1 check("t5_hold_in_ready", {31'b0, f_in_ready}, 32'd0);
      tick();
      check("t5_hold_valid", {31'b0, f_out_valid}, 32'd1);
      check("t5_hold_wR", {27'b0, f_out_wR}, 32'd9);
      check("t5_hold_rD1", f_out_rD1, 32'h1234);
    end
    out_ready = 1;
    #1 check("t5_release_in_ready", {31'b0, f_in_ready}, 32'd1);
    tick();
    check("t5_next_wR", {27'b0, f_out_wR}, 32'd10);
    check("t5_next_rD1", f_out_rD1, 32'hDEAD);

    // 6: immediate formats
    in_inst = 32'hFFF00093; in_sext_op = 0; tick();
    check("t6_imm_I", f_out_ext, 32'hFFFFFFFF);
    in_inst = 32'h80000F80; in_sext_op = 1; tick();
    check("t6_imm_S", f_out_ext, 32'hFFFFF81F);
    in_sext_op = 2; tick();
    check("t6_imm_B", f_out_ext, 32'hFFFFF81E);
    in_inst = 32'h12345037; in_sext_op = 3; tick();
    check("t6_imm_U", f_out_ext, 32'h12345000);
    in_inst = 32'h800000EF; in_sext_op = 4; tick();
    check("t6_imm_J_neg", f_out_ext, 32'hFFF00000);
    in_inst = 32'h7FFFF06F; in_sext_op = 4; tick();
    check("t6_imm_J_pos", f_out_ext, 32'h000FFFFE);
    in_sext_op = 5; tick();
    check("t6_imm_other", f_out_ext, 32'd0);

    // flush alongside a valid input
    set_inst(5, 0, 11); flush = 1;
    #1 check("t6_flush_in_ready", {31'b0, f_in_ready}, 32'd0);
    tick();
    check("t6_flush_valid", {31'b0, f_out_valid}, 32'd0);
    // flush overrides a stall
    flush = 0; tick();
    check("t6_reload_valid", {31'b0, f_out_valid}, 32'd1);
    in_valid = 0; out_ready = 0; flush = 1; tick();
    check("t6_flush_stall", {31'b0, f_out_valid}, 32'd0);
    flush = 0; out_ready = 1;

    // reset asserted mid-stall clears the stage and the RF
    in_valid = 1; set_inst(5, 0, 12); tick();
    check("rst_pre_valid", {31'b0, f_out_valid}, 32'd1);
    in_valid = 0; out_ready = 0;
    #2 rst_n = 0;
    #1;
    check("rst_mid_valid", {31'b0, f_out_valid}, 32'd0);
    check("rst_mid_rD1", f_out_rD1, 32'd0);
    #1 rst_n = 1;
    out_ready = 1; in_valid = 1; set_inst(0, 5, 13);
    tick();
    check("rst_rf_cleared", f_out_rD2, 32'd0);
    check("rst_after_valid", {31'b0, f_out_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
